fifo_ctrl: RTL

- Pointer and flag controller placed directly upstream of the synchronous register-file RAM; together they form a synchronous FIFO.
- Accepts push/pop requests and drives the RAM write enable, write address and read address.
- Tracks occupancy; provides full/empty and almost-full/almost-empty flags, plus sticky overflow/underflow error flags.
- Produces a read-valid strobe aligned with the RAM's one-cycle registered read data.

---
 rtl/fifo_ctrl_if.sv | 32 +++
 rtl/fifo_ctrl.sv | 110 +++++++++++
 2 files changed

// File: rtl/fifo_ctrl_if.sv
// Request/flag bundle between a FIFO user (master) and the fifo_ctrl pointer
// controller (slave), which also drives the register-file RAM addresses.
interface fifo_ctrl_if #(
   parameter int ADDR_WIDTH = 2
);
   logic                  i_wr;
   logic                  i_rd;
   logic                  i_clr_err;
   logic                  o_wr_en;
   logic [ADDR_WIDTH-1:0] o_w_addr;
   logic [ADDR_WIDTH-1:0] o_r_addr;
   logic                  o_rd_valid;
   logic                  o_full;
   logic                  o_empty;
   logic                  o_almost_full;
   logic                  o_almost_empty;
   logic [ADDR_WIDTH:0]   o_count;
   logic                  o_overflow;
   logic                  o_underflow;

   modport master (
      output i_wr, i_rd, i_clr_err,
      input  o_wr_en, o_w_addr, o_r_addr, o_rd_valid, o_full, o_empty,
             o_almost_full, o_almost_empty, o_count, o_overflow, o_underflow
   );

   modport slave (
      input  i_wr, i_rd, i_clr_err,
      output o_wr_en, o_w_addr, o_r_addr, o_rd_valid, o_full, o_empty,
             o_almost_full, o_almost_empty, o_count, o_overflow, o_underflow
   );
endinterface

// File: rtl/fifo_ctrl.sv
// Pointer and flag controller for a synchronous FIFO built around a register-file
// RAM with one-cycle registered read data (old word returned on same-address collision).
module fifo_ctrl #(
   parameter int ADDR_WIDTH    = 2,
   parameter int AFULL_THRESH  = 2**ADDR_WIDTH - 1,
   parameter int AEMPTY_THRESH = 1
) (
   input logic        i_clk,
   input logic        i_reset,
   fifo_ctrl_if.slave bus
);

   localparam int              PTR_W      = ADDR_WIDTH + 1;
   localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
   localparam logic [PTR_W-1:0] PTR_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [PTR_W-1:0] AFULL_LVL  = PTR_W'(AFULL_THRESH);
   localparam logic [PTR_W-1:0] AEMPTY_LVL = PTR_W'(AEMPTY_THRESH);

   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic             rd_valid_r;
   logic             overflow_r;
   logic             underflow_r;

   logic [PTR_W-1:0] wr_ptr_nxt_s;
   logic [PTR_W-1:0] rd_ptr_nxt_s;
   logic             overflow_nxt_s;
   logic             underflow_nxt_s;
   logic [PTR_W-1:0] count_s;
   logic             empty_s;
   logic             full_s;
   logic             rd_ok_s;
   logic             wr_ok_s;

   // Occupancy, flags and accept decisions from the registered pointers.
   always_comb begin
      count_s = wr_ptr_r - rd_ptr_r;
      empty_s = (wr_ptr_r == rd_ptr_r);
      full_s  = (wr_ptr_r[ADDR_WIDTH] != rd_ptr_r[ADDR_WIDTH]) &&
                (wr_ptr_r[ADDR_WIDTH-1:0] == rd_ptr_r[ADDR_WIDTH-1:0]);
      rd_ok_s = bus.i_rd & ~empty_s;
      // A pop in the same cycle frees the slot, so a push into a full FIFO is safe.
      wr_ok_s = bus.i_wr & (~full_s | rd_ok_s);
   end

   // Next pointer values; rejected requests leave the pointers untouched.
   always_comb begin
      if (wr_ok_s) begin
         wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
      end else begin
         wr_ptr_nxt_s = wr_ptr_r + PTR_ZERO;
      end
      if (rd_ok_s) begin
         rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
      end else begin
         rd_ptr_nxt_s = rd_ptr_r + PTR_ZERO;
      end
   end

   // Sticky error flags; a new error in the clearing cycle keeps the flag set.
   always_comb begin
      if (bus.i_wr & ~wr_ok_s) begin
         overflow_nxt_s = 1'b1;
      end else if (bus.i_clr_err) begin
         overflow_nxt_s = 1'b0;
      end else begin
         overflow_nxt_s = overflow_r;
      end
      if (bus.i_rd & ~rd_ok_s) begin
         underflow_nxt_s = 1'b1;
      end else if (bus.i_clr_err) begin
         underflow_nxt_s = 1'b0;
      end else begin
         underflow_nxt_s = underflow_r;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         wr_ptr_r    <= PTR_ZERO;
         rd_ptr_r    <= PTR_ZERO;
         rd_valid_r  <= 1'b0;
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         wr_ptr_r    <= wr_ptr_nxt_s;
         rd_ptr_r    <= rd_ptr_nxt_s;
         rd_valid_r  <= rd_ok_s;
         overflow_r  <= overflow_nxt_s;
         underflow_r <= underflow_nxt_s;
      end
   end

   // Output mapping; write enable is masked while reset holds the pointers.
   always_comb begin
      bus.o_wr_en        = wr_ok_s & ~i_reset;
      bus.o_w_addr       = wr_ptr_r[ADDR_WIDTH-1:0];
      bus.o_r_addr       = rd_ptr_r[ADDR_WIDTH-1:0];
      bus.o_rd_valid     = rd_valid_r;
      bus.o_full         = full_s;
      bus.o_empty        = empty_s;
      bus.o_almost_full  = (count_s >= AFULL_LVL);
      bus.o_almost_empty = (count_s <= AEMPTY_LVL);
      bus.o_count        = count_s;
      bus.o_overflow     = overflow_r;
      bus.o_underflow    = underflow_r;
   end

endmodule
